// File: rtl/alu_issue_if.sv
// Bundle of the upstream op, the external ALU hookup and the registered downstream
// stage of the execute-stage issue block.
interface alu_issue_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic [3:0]       alu_control;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             br_taken;
    logic [4:0]       rd;
    logic             illegal;
    logic [CNT_W-1:0] count;

    modport slave (
        input  req_valid, instr, pc, rs1, rs2, imm, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_control, alu_a, alu_b, rsp_valid, result, zero, br_taken,
               rd, illegal, count
    );

    modport master (
        output req_valid, instr, pc, rs1, rs2, imm, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_control, alu_a, alu_b, rsp_valid, result, zero, br_taken,
               rd, illegal, count
    );
endinterface

// File: rtl/alu_issue.sv
// RV64I execute-stage front end: decodes the ALU control code, steers operands to an
// external combinational ALU, and registers its result into a 1-deep valid/ready stage.
module alu_issue #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    alu_issue_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_SLT  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0110;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_field_s;
    logic [3:0]      ctrl_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic            illegal_s;
    logic            br_taken_s;
    logic [4:0]      rd_s;
    logic            ready_s;
    logic            accept_s;

    logic             valid_r;
    logic [XLEN-1:0]  result_r;
    logic             zero_r;
    logic             br_taken_r;
    logic [4:0]       rd_r;
    logic             illegal_r;
    logic [CNT_W-1:0] count_r;

    assign opcode_s   = bus.instr[6:0];
    assign funct3_s   = bus.instr[14:12];
    assign funct7_s   = bus.instr[31:25];
    assign rd_field_s = bus.instr[11:7];

    // Decode: control code, operand steering, destination and branch outcome
    always_comb begin
        ctrl_s     = CTRL_ADD;
        a_s        = '0;
        b_s        = '0;
        illegal_s  = 1'b1;
        br_taken_s = 1'b0;
        rd_s       = 5'd0;
        case (opcode_s)
            OPC_OP: begin
                ctrl_s = {funct3_s, bus.instr[30]};
                a_s    = bus.rs1;
                b_s    = bus.rs2;
                rd_s   = rd_field_s;
                if (funct7_s == 7'b0000000) begin
                    illegal_s = 1'b0;
                end else if ((funct7_s == 7'b0100000) &&
                             ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    illegal_s = 1'b0;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // Only the shift-right pair uses instr[30]; for ADDI it is just immediate bits
                ctrl_s    = {funct3_s, (funct3_s == 3'b101) ? bus.instr[30] : 1'b0};
                a_s       = bus.rs1;
                b_s       = bus.imm;
                rd_s      = rd_field_s;
                illegal_s = 1'b0;
            end
            OPC_LOAD: begin
                a_s       = bus.rs1;
                b_s       = bus.imm;
                rd_s      = rd_field_s;
                illegal_s = 1'b0;
            end
            OPC_STORE: begin
                a_s       = bus.rs1;
                b_s       = bus.imm;
                illegal_s = 1'b0;
            end
            OPC_BRANCH: begin
                a_s       = bus.rs1;
                b_s       = bus.rs2;
                illegal_s = 1'b0;
                case (funct3_s)
                    3'b000: begin ctrl_s = CTRL_SUB;  br_taken_s = bus.alu_zero;       end
                    3'b001: begin ctrl_s = CTRL_SUB;  br_taken_s = !bus.alu_zero;      end
                    3'b100: begin ctrl_s = CTRL_SLT;  br_taken_s = bus.alu_result[0];  end
                    3'b101: begin ctrl_s = CTRL_SLT;  br_taken_s = !bus.alu_result[0]; end
                    3'b110: begin ctrl_s = CTRL_SLTU; br_taken_s = bus.alu_result[0];  end
                    3'b111: begin ctrl_s = CTRL_SLTU; br_taken_s = !bus.alu_result[0]; end
                    default: begin
                        ctrl_s     = CTRL_ADD;
                        br_taken_s = 1'b0;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                b_s       = bus.imm;
                rd_s      = rd_field_s;
                illegal_s = 1'b0;
            end
            OPC_AUIPC: begin
                a_s       = bus.pc;
                b_s       = bus.imm;
                rd_s      = rd_field_s;
                illegal_s = 1'b0;
            end
            default: begin
                ctrl_s    = CTRL_ADD;
                illegal_s = 1'b1;
            end
        endcase
    end

    assign bus.alu_control = ctrl_s;
    assign bus.alu_a       = a_s;
    assign bus.alu_b       = b_s;

    assign ready_s  = !valid_r || bus.rsp_ready;
    assign accept_s = bus.req_valid && ready_s;

    // Output stage: capture on accept, drain on downstream ready, hold otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r    <= 1'b0;
            result_r   <= '0;
            zero_r     <= 1'b0;
            br_taken_r <= 1'b0;
            rd_r       <= 5'd0;
            illegal_r  <= 1'b0;
            count_r    <= '0;
        end else if (accept_s) begin
            valid_r    <= 1'b1;
            result_r   <= bus.alu_result;
            zero_r     <= bus.alu_zero;
            br_taken_r <= br_taken_s;
            rd_r       <= rd_s;
            illegal_r  <= illegal_s;
            count_r    <= count_r + CNT_W'(1);
        end else if (bus.rsp_ready) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.br_taken  = br_taken_r;
    assign bus.rd        = rd_r;
    assign bus.illegal   = illegal_r;
    assign bus.count     = count_r;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: table of decode/execute vectors plus hand-written
// backpressure and reset-while-valid sequences, with a behavioural model of the external ALU.
module tb_alu_issue;
    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111,
                           AUI = 7'b0010111, BAD = 7'b1111111;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc, rs1, rs2, imm;
        logic [3:0]  ctrl;
        logic [63:0] a, b, res;
        logic        zero, br, ill;
        logic [4:0]  rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    alu_issue_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    alu_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external 64-bit ALU
    always_comb begin
        case (bus.alu_control)
            4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a << bus.alu_b[5:0];
            4'b0100: bus.alu_result = {63'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'b0110: bus.alu_result = {63'd0, bus.alu_a < bus.alu_b};
            4'b1000: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b1010: bus.alu_result = bus.alu_a >> bus.alu_b[5:0];
            4'b1011: bus.alu_result = $unsigned($signed(bus.alu_a) >>> bus.alu_b[5:0]);
            4'b1100: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b1110: bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = 64'd0;
        endcase
        bus.alu_zero = (bus.alu_result == 64'd0);
    end

    function automatic logic [31:0] ins(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                        logic [6:0] opc);
        return {f7, 10'd0, f3, rd, opc};
    endfunction

    function automatic vec_t mk(logic [31:0] instr, logic [63:0] pc, logic [63:0] rs1,
                                logic [63:0] rs2, logic [63:0] imm, logic [3:0] ctrl,
                                logic [63:0] a, logic [63:0] b, logic [63:0] res,
                                logic zero, logic br, logic ill, logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.ctrl = ctrl; v.a = a; v.b = b; v.res = res;
        v.zero = zero; v.br = br; v.ill = ill; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic ready, input vec_t v);
        bus.req_valid = valid;
        bus.rsp_ready = ready;
        bus.instr     = v.instr;
        bus.pc        = v.pc;
        bus.rs1       = v.rs1;
        bus.rs2       = v.rs2;
        bus.imm       = v.imm;
    endtask

    task automatic chk_out(input string tag, input logic valid, input logic [63:0] res,
                           input logic zero, input logic br, input logic [4:0] rd,
                           input logic ill, input logic [31:0] cnt);
        chk({tag, ".valid"},   64'(bus.rsp_valid), 64'(valid));
        chk({tag, ".result"},  bus.result, res);
        chk({tag, ".zero"},    64'(bus.zero), 64'(zero));
        chk({tag, ".br"},      64'(bus.br_taken), 64'(br));
        chk({tag, ".rd"},      64'(bus.rd), 64'(rd));
        chk({tag, ".illegal"}, 64'(bus.illegal), 64'(ill));
        chk({tag, ".count"},   64'(bus.count), 64'(cnt));
    endtask

    initial begin
        vec_t x, y, ill_v;
        logic [31:0] cnt;

        vecs.push_back(mk(ins(7'h00,3'd0,5'd5,OP),  64'd0, 64'd5, 64'd7, 64'd0, 4'b0000, 64'd5, 64'd7, 64'd12, 1'b0,1'b0,1'b0,5'd5));
        vecs.push_back(mk(ins(7'h20,3'd0,5'd6,OP),  64'd0, 64'd9, 64'd9, 64'd0, 4'b0001, 64'd9, 64'd9, 64'd0,  1'b1,1'b0,1'b0,5'd6));
        vecs.push_back(mk(ins(7'h00,3'd0,5'd3,BR),  64'd0, 64'd9, 64'd9, 64'd0, 4'b0001, 64'd9, 64'd9, 64'd0,  1'b1,1'b1,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h20,3'd5,5'd7,OPI), 64'd0, -64'sd16, 64'd0, 64'd2, 4'b1011, -64'sd16, 64'd2, -64'sd4, 1'b0,1'b0,1'b0,5'd7));
        vecs.push_back(mk(ins(7'h60,3'd0,5'd8,OPI), 64'd0, 64'd1000, 64'd0, -64'sd1024, 4'b0000, 64'd1000, -64'sd1024, -64'sd24, 1'b0,1'b0,1'b0,5'd8));
        vecs.push_back(mk(ins(7'h00,3'd4,5'd0,BR),  64'd0, -64'sd1, 64'd1, 64'd0, 4'b0100, -64'sd1, 64'd1, 64'd1, 1'b0,1'b1,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd6,5'd0,BR),  64'd0, -64'sd1, 64'd1, 64'd0, 4'b0110, -64'sd1, 64'd1, 64'd0, 1'b1,1'b0,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd1,5'd2,BR),  64'd0, 64'd3, 64'd3, 64'd0, 4'b0001, 64'd3, 64'd3, 64'd0, 1'b1,1'b0,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd5,5'd0,BR),  64'd0, 64'd1, -64'sd1, 64'd0, 4'b0100, 64'd1, -64'sd1, 64'd0, 1'b1,1'b1,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd7,5'd0,BR),  64'd0, 64'd1, -64'sd1, 64'd0, 4'b0110, 64'd1, -64'sd1, 64'd1, 1'b0,1'b0,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd0,5'd9,LUI), 64'd0, 64'd77, 64'd0, 64'h12345000, 4'b0000, 64'd0, 64'h12345000, 64'h12345000, 1'b0,1'b0,1'b0,5'd9));
        vecs.push_back(mk(ins(7'h00,3'd0,5'd10,AUI), 64'h1000, 64'd5, 64'd0, 64'h20, 4'b0000, 64'h1000, 64'h20, 64'h1020, 1'b0,1'b0,1'b0,5'd10));
        vecs.push_back(mk(ins(7'h00,3'd3,5'd4,ST),  64'd0, 64'h100, 64'h55, 64'd8, 4'b0000, 64'h100, 64'd8, 64'h108, 1'b0,1'b0,1'b0,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd3,5'd11,LD), 64'd0, 64'h200, 64'd0, -64'sd8, 4'b0000, 64'h200, -64'sd8, 64'h1F8, 1'b0,1'b0,1'b0,5'd11));
        vecs.push_back(mk(ins(7'h00,3'd4,5'd12,OP), 64'd0, 64'hF0, 64'hFF, 64'd0, 4'b1000, 64'hF0, 64'hFF, 64'h0F, 1'b0,1'b0,1'b0,5'd12));
        vecs.push_back(mk(ins(7'h20,3'd5,5'd13,OP), 64'd0, -64'sd8, 64'd1, 64'd0, 4'b1011, -64'sd8, 64'd1, -64'sd4, 1'b0,1'b0,1'b0,5'd13));
        vecs.push_back(mk(ins(7'h00,3'd6,5'd14,OPI), 64'd0, 64'h0F, 64'd0, 64'hF0, 4'b1100, 64'h0F, 64'hF0, 64'hFF, 1'b0,1'b0,1'b0,5'd14));
        vecs.push_back(mk(ins(7'h00,3'd7,5'd15,OPI), 64'd0, 64'hFF, 64'd0, 64'h0F, 4'b1110, 64'hFF, 64'h0F, 64'h0F, 1'b0,1'b0,1'b0,5'd15));
        vecs.push_back(mk(ins(7'h00,3'd1,5'd16,OPI), 64'd0, 64'd1, 64'd0, 64'd4, 4'b0010, 64'd1, 64'd4, 64'd16, 1'b0,1'b0,1'b0,5'd16));
        vecs.push_back(mk(ins(7'h00,3'd5,5'd17,OPI), 64'd0, 64'h80, 64'd0, 64'd3, 4'b1010, 64'h80, 64'd3, 64'h10, 1'b0,1'b0,1'b0,5'd17));
        vecs.push_back(mk(ins(7'h01,3'd0,5'd0,OP),  64'd0, 64'd2, 64'd3, 64'd0, 4'b0000, 64'd2, 64'd3, 64'd5, 1'b0,1'b0,1'b1,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd2,5'd0,BR),  64'd0, 64'd1, 64'd2, 64'd0, 4'b0000, 64'd1, 64'd2, 64'd3, 1'b0,1'b0,1'b1,5'd0));
        vecs.push_back(mk(ins(7'h00,3'd0,5'd5,BAD), 64'd8, 64'd4, 64'd4, 64'd4, 4'b0000, 64'd0, 64'd0, 64'd0, 1'b1,1'b0,1'b1,5'd0));

        // Reset with i_valid high: the op must be ignored
        drive(1'b1, 1'b1, vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rst.ready", 64'(bus.req_ready), 64'd1);
        chk_out("rst", 1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);

        cnt = 32'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, vecs[i]);
            #1;
            chk($sformatf("v%0d.ctrl", i), 64'(bus.alu_control), 64'(vecs[i].ctrl));
            chk($sformatf("v%0d.a", i), bus.alu_a, vecs[i].a);
            chk($sformatf("v%0d.b", i), bus.alu_b, vecs[i].b);
            chk($sformatf("v%0d.ready", i), 64'(bus.req_ready), 64'd1);
            @(posedge clk);
            #1;
            cnt++;
            chk_out($sformatf("v%0d", i), 1'b1, vecs[i].res, vecs[i].zero, vecs[i].br,
                    vecs[i].rd, vecs[i].ill, cnt);
        end

        // Drain
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain.valid", 64'(bus.rsp_valid), 64'd0);
        chk("drain.count", 64'(bus.count), 64'(cnt));

        // Backpressure: X captured, Y waits three cycles, then swaps in
        x = mk(ins(7'h00,3'd0,5'd20,OP), 64'd0, 64'd100, 64'd1, 64'd0, 4'b0000, 64'd100, 64'd1, 64'd101, 1'b0,1'b0,1'b0,5'd20);
        y = mk(ins(7'h20,3'd0,5'd21,OP), 64'd0, 64'd50, 64'd8, 64'd0, 4'b0001, 64'd50, 64'd8, 64'd42, 1'b0,1'b0,1'b0,5'd21);
        @(negedge clk);
        drive(1'b1, 1'b0, x);
        @(posedge clk);
        #1;
        cnt++;
        chk_out("bpX", 1'b1, 64'd101, 1'b0, 1'b0, 5'd20, 1'b0, cnt);
        @(negedge clk);
        drive(1'b1, 1'b0, y);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.ready", k), 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk_out($sformatf("bp%0d", k), 1'b1, 64'd101, 1'b0, 1'b0, 5'd20, 1'b0, cnt);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bpY.ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        cnt++;
        chk_out("bpY", 1'b1, 64'd42, 1'b0, 1'b0, 5'd21, 1'b0, cnt);

        // Illegal opcode held downstream, then reset mid-transfer
        ill_v = vecs[vecs.size() - 1];
        @(negedge clk);
        drive(1'b1, 1'b1, ill_v);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cnt++;
        chk_out("ill", 1'b1, 64'd0, 1'b1, 1'b0, 5'd0, 1'b1, cnt);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, vecs[0]);
        @(posedge clk);
        #1;
        chk_out("rst2", 1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rst2.ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        chk_out("post", 1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
